// File: rtl/reg_cut_timeout.sv
// reg_cut_timeout: register-interface pipeline cut with a hung-slave timeout that forces an error response upstream.
package reg_pkg;
   typedef struct packed {
      logic        valid;
      logic        write;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } reg_req_t;
   typedef struct packed {
      logic        error;
      logic        ready;
      logic [31:0] rdata;
   } reg_resp_t;
endpackage

module reg_cut_timeout #(
   parameter int unsigned TimeoutCycles = 256,
   parameter logic [31:0] ErrData       = 32'hBADCAB1E
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  reg_pkg::reg_req_t   up_req_i,
   output reg_pkg::reg_resp_t  up_rsp_o,
   output reg_pkg::reg_req_t   dn_req_o,
   input  reg_pkg::reg_resp_t  dn_rsp_i,
   output logic                busy_o,
   output logic                timeout_o,
   output logic [15:0]         timeout_cnt_o
);
   localparam int CW = TimeoutCycles == 0 ? 1 : $clog2(TimeoutCycles + 1);
   localparam logic [CW-1:0] LAST = CW'(TimeoutCycles == 0 ? 0 : TimeoutCycles - 1);
   localparam bit TIMED = TimeoutCycles != 0;
   typedef enum logic [1:0] {IDLE, FWD, RESP} state_t;
   state_t            state;
   reg_pkg::reg_req_t req_q;
   logic              rsp_err;
   logic [31:0]       rsp_data;
   logic [CW-1:0]     cnt;
   logic              expire;
   // a downstream ready in the expiry cycle wins over the timeout
   assign expire    = state == FWD && !dn_rsp_i.ready && TIMED && cnt == LAST;
   assign timeout_o = expire;
   assign busy_o    = state != IDLE;
   assign up_rsp_o  = state == RESP ? '{error: rsp_err, ready: 1'b1, rdata: rsp_data} : '0;
   always_comb begin
      dn_req_o       = req_q;
      dn_req_o.valid = state == FWD;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         req_q         <= '0;
         rsp_err       <= 1'b0;
         rsp_data      <= '0;
         cnt           <= '0;
         timeout_cnt_o <= '0;
      end else begin
         case (state)
            IDLE: if (up_req_i.valid) begin
               req_q       <= up_req_i;
               req_q.valid <= 1'b0;
               cnt         <= '0;
               state       <= FWD;
            end
            FWD: begin
               cnt <= TIMED ? cnt + CW'(1) : '0;
               if (dn_rsp_i.ready) begin
                  rsp_err  <= dn_rsp_i.error;
                  rsp_data <= req_q.write ? '0 : dn_rsp_i.rdata;
                  state    <= RESP;
               end else if (expire) begin
                  rsp_err       <= 1'b1;
                  rsp_data      <= req_q.write ? '0 : ErrData;
                  timeout_cnt_o <= timeout_cnt_o + 16'(timeout_cnt_o != 16'hFFFF);
                  state         <= RESP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_cut_timeout.sv
// tb_reg_cut_timeout: directed table plus randomized transactions checked against a per-transaction reference model.
module tb_reg_cut_timeout;
   import reg_pkg::*;
   localparam int T = 8;
   localparam logic [31:0] ERR = 32'hBADCAB1E;

   logic        clk = 1'b0;
   logic        rst;
   reg_req_t    up_req, dn_req;
   reg_resp_t   up_rsp, dn_rsp;
   logic        busy, tmo;
   logic [15:0] tcnt;
   int          n_chk = 0, n_pass = 0, exp_cnt = 0, cyc = 0, last_resp = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   reg_cut_timeout #(.TimeoutCycles(T), .ErrData(ERR)) dut (
      .clk_i(clk), .rst_i(rst), .up_req_i(up_req), .up_rsp_o(up_rsp),
      .dn_req_o(dn_req), .dn_rsp_i(dn_rsp), .busy_o(busy), .timeout_o(tmo),
      .timeout_cnt_o(tcnt)
   );

   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          delay;
      logic [31:0] sdata;
      logic        serr;
      logic        exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // the slave answers after `delay` stall cycles; the bus gives up after T cycles in flight
   function automatic reg_resp_t ref_rsp(input logic write, input int delay, input logic [31:0] sdata, input logic serr);
      bit timed = delay >= T;
      ref_rsp.ready = 1'b1;
      ref_rsp.error = timed ? 1'b1 : serr;
      ref_rsp.rdata = write ? 32'h0 : timed ? ERR : sdata;
   endfunction

   task automatic run_txn(input vec_t v, input reg_resp_t exp, input bit scramble);
      reg_req_t r;
      int nf;
      bit timed;
      r = '{valid: 1'b1, write: v.write, wstrb: v.wstrb, addr: v.addr, wdata: v.wdata};
      timed = v.delay >= T;
      nf = timed ? T : v.delay + 1;
      @(posedge clk); #1;
      up_req = r;
      dn_rsp = '0;
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_dn_valid", dn_req.valid, 0);
      chk("idle_up_ready", up_rsp.ready, 0);
      for (int k = 0; k < nf; k++) begin
         @(posedge clk); #1;
         if (scramble) up_req = '{valid: 1'($urandom), write: 1'($urandom), wstrb: 4'($urandom), addr: $urandom, wdata: $urandom};
         dn_rsp = (k == v.delay) ? '{error: v.serr, ready: 1'b1, rdata: v.sdata}
                                 : '{error: 1'($urandom), ready: 1'b0, rdata: $urandom};
         @(negedge clk);
         chk("fwd_dn_req", dn_req, r);
         chk("fwd_timeout", tmo, timed && k == T - 1);
         chk("fwd_up_ready", up_rsp.ready, 0);
         chk("fwd_busy", busy, 1);
      end
      if (timed && exp_cnt < 16'hFFFF) exp_cnt++;
      @(posedge clk); #1;
      up_req = '0;
      dn_rsp = '0;
      @(negedge clk);
      last_resp = cyc;
      chk("resp", up_rsp, exp);
      chk("resp_dn_valid", dn_req.valid, 0);
      chk("resp_timeout", tmo, 0);
      chk("timeout_cnt", tcnt, 16'(exp_cnt));
   endtask

   vec_t tbl[6];
   vec_t v;
   reg_req_t r;
   int prev;

   initial begin
      tbl[0] = '{1'b0, 32'h10, 32'h0,        4'hF,   0, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D};
      tbl[1] = '{1'b1, 32'h20, 32'h12345678, 4'b0011, 5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      tbl[2] = '{1'b0, 32'h30, 32'h0,        4'hF, 100, 32'h11111111, 1'b0, 1'b1, ERR};
      tbl[3] = '{1'b0, 32'h40, 32'h0,        4'hF,   7, 32'h600DDA7A, 1'b0, 1'b0, 32'h600DDA7A};
      tbl[4] = '{1'b1, 32'h50, 32'hA5A5A5A5, 4'hC, 100, 32'h22222222, 1'b0, 1'b1, 32'h0};
      tbl[5] = '{1'b0, 32'h60, 32'h0,        4'hF,   2, 32'h00000055, 1'b1, 1'b1, 32'h00000055};
      rst = 1'b1;
      up_req = '0;
      dn_rsp = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_up_rsp", up_rsp, 0);
      chk("rst_dn_req", dn_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", tmo, 0);
      chk("rst_tcnt", tcnt, 0);

      for (int i = 0; i < 6; i++)
         run_txn(tbl[i], '{error: tbl[i].exp_err, ready: 1'b1, rdata: tbl[i].exp_rdata}, 1'b0);

      for (int i = 0; i < 3; i++) begin
         prev = last_resp;
         v = '{1'b0, 32'h100 + 32'(4 * i), 32'h0, 4'hF, 0, 32'h1000 + 32'(i), 1'b0, 1'b0, 32'h0};
         run_txn(v, ref_rsp(1'b0, 0, v.sdata, 1'b0), 1'b0);
         if (i > 0) chk("b2b_spacing", 32'(last_resp - prev), 3);
      end

      r = '{valid: 1'b1, write: 1'b0, wstrb: 4'hF, addr: 32'h70, wdata: 32'h0};
      @(posedge clk); #1 up_req = r;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      up_req = '0;
      @(posedge clk); #1 rst = 1'b0;
      exp_cnt = 0;
      @(negedge clk);
      chk("midrst_dn_valid", dn_req.valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_up_ready", up_rsp.ready, 0);
      chk("midrst_tcnt", tcnt, 0);
      @(negedge clk);
      chk("midrst_up_ready2", up_rsp.ready, 0);
      v = '{1'b0, 32'h80, 32'h0, 4'hF, 1, 32'h0BADF00D, 1'b0, 1'b0, 32'h0};
      run_txn(v, ref_rsp(1'b0, 1, v.sdata, 1'b0), 1'b0);

      for (int i = 0; i < 40; i++) begin
         v.write = 1'($urandom);
         v.addr  = $urandom;
         v.wdata = $urandom;
         v.wstrb = 4'($urandom);
         v.delay = int'($urandom_range(0, 10));
         v.sdata = $urandom;
         v.serr  = ($urandom_range(0, 3) == 0);
         run_txn(v, ref_rsp(v.write, v.delay, v.sdata, v.serr), 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/reg_cut_timeout.md
Name: reg_cut_timeout

Overview:
- Single-entry register-interface pipeline cut placed between a register-interface bus master (crossbar/bridge output) and a peripheral register file.
- Registers the request path and the response path, which breaks long combinational req->resp timing paths.
- Guards against hung slaves with a configurable timeout. On expiry it returns an error response upstream.
- Uses the codebase's reg_pkg::reg_req_t (70 bits: valid, write, wstrb[3:0], addr[31:0], wdata[31:0]) and reg_pkg::reg_resp_t (34 bits: error, ready, rdata[31:0]) on both sides.

Parameters:
- TimeoutCycles, 256: maximum cycles spent in FWD before an error is forced; 0 disables the timeout.
- ErrData, 32'hBADCAB1E: rdata returned upstream on a timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- up_req_i  in  reg_req_t (70)  request from upstream master.
- up_rsp_o  out  reg_resp_t (34)  response to upstream master.
- dn_req_o  out  reg_req_t (70)  registered request to downstream slave.
- dn_rsp_i  in  reg_resp_t (34)  response from downstream slave.
- busy_o  out  1  high whenever state != IDLE.
- timeout_o  out  1  one-cycle pulse when a timeout fires.
- timeout_cnt_o  out  16  saturating count of timeouts since reset.

Behaviour:
- Protocol: a transaction completes in the cycle where valid && ready. The master holds its request stable until then.
- Reset values: state=IDLE; all req_q fields 0; rsp_q rdata=0, error=0; counter=0; timeout_cnt_o=0; up_rsp_o all 0; dn_req_o all 0; busy_o=0; timeout_o=0.
- FSM IDLE:
  - up_rsp_o.ready=0.
  - If up_req_i.valid, capture write/wstrb/addr/wdata into req_q, clear the timeout counter, go FWD.
- FSM FWD:
  - dn_req_o = req_q with valid=1. Fields stay constant for the whole state.
  - Counter increments each cycle.
  - If dn_rsp_i.ready: capture rsp_q.error=dn_rsp_i.error and rsp_q.rdata = write ? 0 : dn_rsp_i.rdata, then go RESP.
  - Else if TimeoutCycles!=0 and counter==TimeoutCycles-1: rsp_q.error=1, rsp_q.rdata = write ? 0 : ErrData, timeout_o=1 for this cycle, timeout_cnt_o += 1 (saturates at 16'hFFFF), go RESP.
  - If ready and timeout expiry coincide, the downstream response wins: no error, no timeout pulse.
- FSM RESP:
  - up_rsp_o.ready=1 with rsp_q error/rdata. dn_req_o.valid=0.
  - Unconditionally go IDLE. The upstream transaction completes this cycle.
- Outside FWD: dn_req_o.valid=0 and the other dn_req_o fields hold req_q.
- Outside RESP: up_rsp_o.ready=0, error=0, rdata=0.
- Latency: downstream ready in the first FWD cycle gives up_rsp_o.ready 2 cycles after up_req_i.valid first rises. Back-to-back throughput is one transaction per 3 cycles minimum.
- A new up_req_i.valid seen in the IDLE cycle following RESP is a new transaction. Changes to up_req_i while in FWD/RESP are ignored; the captured req_q is authoritative.
- Counter width is $clog2(TimeoutCycles+1), minimum 1. With TimeoutCycles=0 the counter is held at 0.
- Reset mid-transaction: the next edge returns to IDLE and dn_req_o.valid drops. The pending transaction is dropped silently: no upstream ready. timeout_cnt_o clears.
- Downstream error=1 together with ready is forwarded as-is. timeout_o and timeout_cnt_o are unaffected.

Test Plan:
- Read, slave ready in the first FWD cycle: addr=0x10, slave rdata=0xCAFEF00D -> dn_req_o.valid for 1 cycle; up_rsp_o.ready 2 cycles after request with rdata=0xCAFEF00D, error=0.
- Write, slave ready after 5 cycles: wdata=0x12345678, wstrb=4'b0011 -> dn_req_o stable for 6 cycles with matching fields; up ready with rdata=0, error=0.
- TimeoutCycles=8, slave never ready -> after 8 FWD cycles timeout_o pulses once; up ready with error=1, rdata=0xBADCAB1E; timeout_cnt_o=1.
- Slave ready exactly in the expiry cycle (TimeoutCycles=8, ready on the 8th FWD cycle) -> error=0, slave rdata returned, timeout_cnt_o unchanged.
- Reset asserted during FWD -> next cycle dn_req_o.valid=0, busy_o=0, no up_rsp_o.ready; a subsequent read completes normally.
- Three back-to-back reads with the slave always ready -> up_rsp_o.ready every 3rd cycle; downstream addresses observed in order.
